// File: rtl/md6_pad_responder.sv
// 6-button pad responder: synchronizes the host select line, tracks the
// select-pulse phase with an idle timeout and drives the registered pin levels.
module md6_pad_responder #(
    parameter int TIMEOUT_CYCLES = 72000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel,
    input  logic        six_btn_en,
    input  logic [11:0] btn,
    output logic [5:0]  pad_out,
    output logic [2:0]  phase
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        PH0 = 3'd0,
        PH1 = 3'd1,
        PH2 = 3'd2,
        PH3 = 3'd3,
        PH4 = 3'd4
    } phase_t;

    logic          sync1;
    logic          sel_s;
    logic          sel_q;
    phase_t        phase_q;
    phase_t        phase_d;
    logic [CW-1:0] idle_q;
    logic [CW-1:0] idle_d;
    logic [5:0]    pad_d;
    logic          fall;
    logic          rise;

    // Reset values of 1 keep a held-high sel from looking like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sel_s <= 1'b1;
            sel_q <= 1'b1;
        end else begin
            sync1 <= sel;
            sel_s <= sync1;
            sel_q <= sel_s;
        end
    end

    assign fall = sel_q & ~sel_s;
    assign rise = ~sel_q & sel_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH0;
            idle_q  <= '0;
            pad_out <= 6'b111111;
        end else begin
            phase_q <= phase_d;
            idle_q  <= idle_d;
            pad_out <= pad_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        idle_d  = idle_q;
        pad_d   = 6'b111111;

        if (fall || rise) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end

        // An edge always beats a coincident timeout.
        if (!six_btn_en) begin
            phase_d = PH0;
        end else if (fall) begin
            case (phase_q)
                PH0:     phase_d = PH1;
                PH1:     phase_d = PH2;
                PH2:     phase_d = PH3;
                default: phase_d = PH4;
            endcase
        end else if (!rise && idle_q == IDLE_MAX) begin
            phase_d = PH0;
        end

        // Bit order, MSB first: pin9, pin6, pin4, pin3, pin2, pin1.
        if (sel_s) begin
            if (phase_d == PH3) begin
                pad_d = {~btn[5], ~btn[4], ~btn[8], ~btn[9], ~btn[10], ~btn[11]};
            end else begin
                pad_d = {~btn[5], ~btn[4], ~btn[0], ~btn[1], ~btn[2], ~btn[3]};
            end
        end else begin
            case (phase_d)
                PH3:     pad_d = {~btn[7], ~btn[6], 4'b0000};
                PH4:     pad_d = {~btn[7], ~btn[6], 4'b1111};
                default: pad_d = {~btn[7], ~btn[6], 2'b00, ~btn[2], ~btn[3]};
            endcase
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_md6_pad_responder.sv
// Randomized and directed bench for md6_pad_responder, compared every cycle
// against a pin-level behavioural model of the pad protocol.
module tb_md6_pad_responder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b1;
    logic        six_btn_en = 1'b1;
    logic [11:0] btn = '0;
    logic [5:0]  pad_out;
    logic [2:0]  phase;

    int checks = 0;
    int failures = 0;

    // Behavioural model state: sel samples seen at past clock edges (newest at back).
    bit         sel_hist[$];
    int         m_phase;
    int         m_idle;
    logic [5:0] m_pad;

    md6_pad_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sel        (sel),
        .six_btn_en (six_btn_en),
        .btn        (btn),
        .pad_out    (pad_out),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Pin levels from the protocol table; a pressed button pulls its pin low.
    function automatic logic [5:0] expected_pad(input int ph, input bit s, input logic [11:0] b);
        bit pin1, pin2, pin3, pin4, pin6, pin9;
        bit r, l, d, u, bb, c, a, st, md, x, y, z;
        {z, y, x, md, st, a, c, bb, u, d, l, r} = b;
        if (s && ph == 3) begin
            pin1 = !z; pin2 = !y; pin3 = !x; pin4 = !md; pin6 = !bb; pin9 = !c;
        end else if (s) begin
            pin1 = !u; pin2 = !d; pin3 = !l; pin4 = !r; pin6 = !bb; pin9 = !c;
        end else if (ph == 3) begin
            pin1 = 0; pin2 = 0; pin3 = 0; pin4 = 0; pin6 = !a; pin9 = !st;
        end else if (ph == 4) begin
            pin1 = 1; pin2 = 1; pin3 = 1; pin4 = 1; pin6 = !a; pin9 = !st;
        end else begin
            pin1 = !u; pin2 = !d; pin3 = 0; pin4 = 0; pin6 = !a; pin9 = !st;
        end
        return {pin9, pin6, pin4, pin3, pin2, pin1};
    endfunction

    task automatic model_reset();
        sel_hist = '{1'b1, 1'b1, 1'b1};
        m_phase  = 0;
        m_idle   = 0;
        m_pad    = 6'b111111;
    endtask

    // One clock edge of the model: the logic sees sel as it was two and three edges ago.
    task automatic model_step();
        bit  s, q, fall, rise, idle_hit;
        s        = sel_hist[1];
        q        = sel_hist[0];
        fall     = q && !s;
        rise     = !q && s;
        idle_hit = (m_idle == TO - 1);
        if (fall || rise) m_idle = 0;
        else if (!idle_hit) m_idle = m_idle + 1;
        if (!six_btn_en) m_phase = 0;
        else if (fall) m_phase = (m_phase >= 4) ? 4 : m_phase + 1;
        else if (!rise && idle_hit) m_phase = 0;
        m_pad = expected_pad(m_phase, s, btn);
        sel_hist.push_back(sel);
        void'(sel_hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        checkOutput("pad_out", 32'(pad_out), 32'(m_pad));
        checkOutput("phase", 32'(phase), 32'(m_phase));
    endtask

    task automatic applyStimulus(input bit s, input bit six, input logic [11:0] b, input int n);
        sel = s;
        six_btn_en = six;
        btn = b;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        checkOutput("async_reset_pad", 32'(pad_out), 32'h3F);
        checkOutput("async_reset_phase", 32'(phase), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        sel = 1'b1;
        btn = '0;
        six_btn_en = 1'b1;
        tick();
        checkOutput("reset_pad", 32'(pad_out), 32'h3F);
        checkOutput("reset_phase", 32'(phase), 32'd0);
        reset_n = 1'b1;

        // Held-high sel after reset, then a U press one cycle later.
        applyStimulus(1, 1, 12'h000, 5);
        applyStimulus(1, 1, 12'h008, 1);
        checkOutput("press_u", 32'(pad_out), 32'b111110);

        // Four select pulses with A|Z held.
        do_reset();
        applyStimulus(1, 1, 12'h840, 4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 12'h840, 6);
            checkOutput("pulse_phase", 32'(phase), 32'(i + 1));
            applyStimulus(1, 1, 12'h840, 6);
            if (i == 2) checkOutput("phase3_high_z", 32'(pad_out), 32'b111110);
        end
        applyStimulus(0, 1, 12'h840, 6);
        checkOutput("no_wrap", 32'(phase), 32'd4);

        // Timeout from phase 3 while sel idles high.
        do_reset();
        applyStimulus(1, 1, 12'h000, 4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 12'h000, 6);
            applyStimulus(1, 1, 12'h000, 6);
        end
        checkOutput("before_timeout", 32'(phase), 32'd3);
        applyStimulus(1, 1, 12'h000, 16);
        checkOutput("timeout_phase", 32'(phase), 32'd0);
        checkOutput("timeout_pad", 32'(pad_out), 32'h3F);

        // Falling edge landing exactly on the timeout cycle, and one cycle late.
        for (int late = 0; late < 2; late++) begin
            do_reset();
            applyStimulus(1, 1, 12'h000, 4);
            applyStimulus(0, 1, 12'h000, 6);
            applyStimulus(1, 1, 12'h000, 6);
            applyStimulus(0, 1, 12'h000, 6);
            applyStimulus(1, 1, 12'h000, 16 + late);
            applyStimulus(0, 1, 12'h000, 4);
            checkOutput(late == 0 ? "edge_beats_timeout" : "timeout_then_edge",
                        32'(phase), late == 0 ? 32'd3 : 32'd1);
        end

        // Three-button mode ignores pulses.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 12'h080, 4);
            checkOutput("three_btn_phase", 32'(phase), 32'd0);
            applyStimulus(1, 0, 12'h080, 4);
        end

        // Dropping six_btn_en mid-sequence.
        applyStimulus(0, 1, 12'h000, 5);
        applyStimulus(1, 1, 12'h000, 5);
        applyStimulus(0, 1, 12'h000, 5);
        applyStimulus(0, 0, 12'h000, 1);
        checkOutput("six_drop", 32'(phase), 32'd0);

        // Asynchronous reset while in phase 3.
        applyStimulus(1, 1, 12'h0FF, 5);
        applyStimulus(0, 1, 12'h0FF, 5);
        applyStimulus(1, 1, 12'h0FF, 5);
        applyStimulus(0, 1, 12'h0FF, 5);
        applyStimulus(1, 1, 12'h0FF, 5);
        applyStimulus(0, 1, 12'h0FF, 5);
        checkOutput("pre_reset_phase", 32'(phase), 32'd3);
        do_reset();

        // Randomized traffic.
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
                          12'($urandom), $urandom_range(1, 20));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
